imem_boot_loader: RTL and testbench

//  Sequences the instruction memory at boot. Receives a program as a byte stream over a

---
 rtl/imem_boot_loader.sv | 109 ++++++++++
 tb/tb_imem_boot_loader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot-time instruction memory loader: takes a length-prefixed byte stream, packs
// little-endian words, writes them to imem and releases the pipeline when finished.
module imem_boot_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              imem_we,
  output logic              cpu_stall,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W-1:0] word_count
);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, WRITE, DONE, ERR} state_t;

  localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

  state_t            state, state_nxt;
  logic [15:0]       len;
  logic [31:0]       wbuf;
  logic [1:0]        byte_idx;
  logic [ADDR_W-1:0] word_ptr;
  logic [15:0]       len_full;
  logic [15:0]       ptr_next;

  assign len_full = {rx_data, len[7:0]};
  assign ptr_next = 16'(word_ptr) + 16'd1;

  always_comb begin
    state_nxt = state;
    rx_ready  = 1'b0;
    imem_we   = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = HDR0;
      HDR0: begin
        rx_ready = 1'b1;
        if (rx_valid) state_nxt = HDR1;
      end
      HDR1: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (len_full == 16'd0)       state_nxt = DONE;
          else if (len_full > MAX_LEN) state_nxt = ERR;
          else                         state_nxt = DATA;
        end
      end
      DATA: begin
        rx_ready = 1'b1;
        if (rx_valid && byte_idx == 2'd3) state_nxt = WRITE;
      end
      WRITE: begin
        imem_we   = 1'b1;
        state_nxt = (ptr_next == len) ? DONE : DATA;
      end
      DONE: if (start) state_nxt = HDR0;
      ERR:  if (start) state_nxt = HDR0;
      default: state_nxt = IDLE;
    endcase
  end

  // Status flags are pure state decodes: DONE/ERR are left only by start or reset,
  // which is exactly when the sticky flags must clear.
  assign cpu_stall  = (state != DONE);
  assign load_done  = (state == DONE);
  assign load_err   = (state == ERR);
  assign imem_wdata = wbuf;
  assign imem_addr  = (state == DONE) ? fetch_pc : {word_ptr[ADDR_W-3:0], 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      len        <= '0;
      wbuf       <= '0;
      byte_idx   <= '0;
      word_ptr   <= '0;
      word_count <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE, DONE, ERR: if (start) word_count <= '0;
        HDR0: if (rx_valid) len[7:0] <= rx_data;
        HDR1: if (rx_valid) begin
          len[15:8] <= rx_data;
          byte_idx  <= '0;
          word_ptr  <= '0;
        end
        DATA: if (rx_valid) begin
          wbuf[{byte_idx, 3'b000} +: 8] <= rx_data;
          byte_idx                      <= byte_idx + 2'd1;
        end
        WRITE: begin
          word_ptr   <= word_ptr + 1'b1;
          word_count <= word_count + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: directed corner sequences, a table of load lengths and
// random loads, checked against a word-packing model of the byte stream.
module tb_imem_boot_loader;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset, start, rx_valid, rx_ready;
  logic [7:0]        rx_data;
  logic [ADDR_W-1:0] fetch_pc, imem_addr, word_count;
  logic [31:0]       imem_wdata;
  logic              imem_we, cpu_stall, load_done, load_err;

  int ncmp = 0, nfail = 0;
  logic [ADDR_W-1:0] wa_q[$];
  logic [31:0]       wd_q[$];
  logic [ADDR_W-1:0] ea_q[$];
  logic [31:0]       ed_q[$];

  imem_boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(256)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .fetch_pc(fetch_pc), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .imem_we(imem_we), .cpu_stall(cpu_stall),
    .load_done(load_done), .load_err(load_err), .word_count(word_count));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Every write strobe is logged; no byte may be accepted in a write cycle.
  always @(negedge clk) if (imem_we) begin
    wa_q.push_back(imem_addr);
    wd_q.push_back(imem_wdata);
    chk("rdy_in_write", 32'(rx_ready), 0);
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk); rx_valid = 1'b0; rx_data = 8'($urandom);
    end
    @(negedge clk);
    while (!rx_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      ncmp++; nfail++;
      $display("FAIL rx_ready_timeout: rx_ready stuck 0 @%0t", $time);
    end
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1 rx_valid = 1'b0;
  endtask

  task automatic wait_end();
    int n = 0;
    @(negedge clk);
    while (!(load_done || load_err) && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) begin
      ncmp++; nfail++;
      $display("FAIL end_timeout: neither load_done nor load_err @%0t", $time);
    end
  endtask

  // Model: word i of the program lands at byte address 4*i, first byte in bits 7:0.
  task automatic model_words(input logic [7:0] bytes[$]);
    ea_q.delete(); ed_q.delete();
    for (int i = 0; i + 3 < bytes.size(); i += 4) begin
      ea_q.push_back(ADDR_W'(4 * i / 4 * 4 / 4 * 4 / 4) << 0);
      ed_q.push_back({bytes[i+3], bytes[i+2], bytes[i+1], bytes[i]});
    end
    for (int i = 0; i < ea_q.size(); i++) ea_q[i] = ADDR_W'(4 * i);
  endtask

  task automatic cmp_writes(input string nm);
    chk({nm, "_nwr"}, 32'(wa_q.size()), 32'(ea_q.size()));
    for (int i = 0; i < ea_q.size() && i < wa_q.size(); i++) begin
      chk({nm, "_addr"}, 32'(wa_q[i]), 32'(ea_q[i]));
      chk({nm, "_data"}, wd_q[i], ed_q[i]);
    end
  endtask

  // Full load of a random program; final flags derived from the length rules.
  task automatic run_load(input string nm, input int len, input int gap_max);
    logic [7:0] bytes[$];
    bit err;
    err = (len > 256);
    pulse_start();
    chk({nm, "_start_done"}, 32'(load_done), 0);
    chk({nm, "_start_err"}, 32'(load_err), 0);
    chk({nm, "_start_wc"}, 32'(word_count), 0);
    wa_q.delete(); wd_q.delete();
    send_byte(8'(len), $urandom_range(0, gap_max));
    send_byte(8'(len >> 8), $urandom_range(0, gap_max));
    if (!err) for (int i = 0; i < 4 * len; i++) begin
      bytes.push_back(8'($urandom));
      send_byte(bytes[i], $urandom_range(0, gap_max));
    end
    wait_end();
    model_words(bytes);
    chk({nm, "_done"}, 32'(load_done), 32'(!err));
    chk({nm, "_err"}, 32'(load_err), 32'(err));
    chk({nm, "_stall"}, 32'(cpu_stall), 32'(err));
    chk({nm, "_wc"}, 32'(word_count), err ? 0 : 32'(len));
    cmp_writes(nm);
  endtask

  typedef struct { int len; int gap_max; } vec_t;
  vec_t vecs[6];

  initial begin
    logic [7:0] prog[$];
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = '0; fetch_pc = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(rx_ready), 0);
    chk("rst_we", 32'(imem_we), 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_stall", 32'(cpu_stall), 1);
    chk("rst_done", 32'(load_done), 0);
    chk("rst_err", 32'(load_err), 0);
    chk("rst_wc", 32'(word_count), 0);
    chk("rst_addr", 32'(imem_addr), 0);

    // Two-word program; first write the cycle after the 4th data byte.
    prog = '{8'h01, 8'h14, 8'h00, 8'h91, 8'h02, 8'h28, 8'h00, 8'h91};
    for (int pass = 0; pass < 2; pass++) begin
      wa_q.delete(); wd_q.delete();
      pulse_start();
      send_byte(8'h02, 0); send_byte(8'h00, 0);
      for (int i = 0; i < 8; i++) begin
        send_byte(prog[i], pass);
        if (i == 3) begin
          chk("w0_we", 32'(imem_we), 1);
          chk("w0_addr", 32'(imem_addr), 0);
          chk("w0_data", imem_wdata, 32'h91001401);
        end
      end
      wait_end();
      model_words(prog);
      chk("p2_done", 32'(load_done), 1);
      chk("p2_stall", 32'(cpu_stall), 0);
      chk("p2_wc", 32'(word_count), 2);
      cmp_writes(pass == 0 ? "p2" : "p2_toggle");
    end

    // DONE: imem address follows fetch_pc combinationally.
    @(negedge clk); fetch_pc = 10'h00C; #1;
    chk("pc_mux", 32'(imem_addr), 32'h00C);
    chk("pc_we", 32'(imem_we), 0);
    fetch_pc = 10'h3F8; #1;
    chk("pc_mux2", 32'(imem_addr), 32'h3F8);

    // Zero-length program.
    wa_q.delete(); wd_q.delete();
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    chk("z_done_now", 32'(load_done), 1);
    repeat (2) @(negedge clk);
    chk("z_nwr", 32'(wa_q.size()), 0);
    chk("z_wc", 32'(word_count), 0);

    // Oversized header, then recovery.
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h01, 0);
    @(negedge clk);
    chk("e_err", 32'(load_err), 1);
    chk("e_stall", 32'(cpu_stall), 1);
    chk("e_done", 32'(load_done), 0);
    run_load("recov", 1, 0);

    // Reset after 6 data bytes of a 2-word load; start in HDR1 must be ignored.
    wa_q.delete(); wd_q.delete();
    pulse_start();
    send_byte(8'h02, 0);
    pulse_start();
    chk("h1_ready", 32'(rx_ready), 1);
    send_byte(8'h00, 0);
    for (int i = 0; i < 6; i++) send_byte(prog[i], 0);
    do_reset();
    chk("mr_ready", 32'(rx_ready), 0);
    chk("mr_done", 32'(load_done), 0);
    chk("mr_stall", 32'(cpu_stall), 1);
    chk("mr_wc", 32'(word_count), 0);
    prog = '{8'h01, 8'h14, 8'h00, 8'h91};
    model_words(prog);
    cmp_writes("mr");

    vecs[0] = '{1, 0};   vecs[1] = '{3, 2};   vecs[2] = '{256, 1};
    vecs[3] = '{257, 0}; vecs[4] = '{65535, 0}; vecs[5] = '{255, 0};
    for (int v = 0; v < 6; v++) run_load($sformatf("tbl%0d", v), vecs[v].len, vecs[v].gap_max);
    for (int r = 0; r < 4; r++) run_load($sformatf("rnd%0d", r), $urandom_range(0, 300), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
